btn_event_sched: RTL and testbench

BTN_EVENT_SCHED -- requirements
Module: btn_event_sched

---
 rtl/btn_event_sched.sv | 148 ++++++++++++++
 tb/tb_btn_event_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_sched.sv
// Button event scheduler: press and auto-repeat detection feeding a small event queue.
// Events carry the button index, the switch levels at enqueue time and a repeat flag.
module btn_event_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_in,
  input  logic [7:0] sw_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_btn,
  output logic [7:0] evt_sw,
  output logic       evt_repeat,
  output logic [4:0] fifo_count,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CW       = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  typedef struct packed {
    logic [2:0] btn;
    logic [7:0] sw;
    logic       rpt;
  } evt_t;

  logic [4:0]    btn_prev_q;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    pend_rpt_q, pend_rpt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rpt_phase_q, rpt_phase_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  evt_t          mem [FIFO_DEPTH];

  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [4:0] sel_onehot;
  logic [4:0] press, pend_left, rpt_bits;
  logic       hold_active, rpt_fire;
  logic       pop, push, drop, full;
  evt_t       wr_entry, head;

  // Lowest pending index wins; one candidate per cycle.
  always_comb begin
    sel_valid  = |pend_q;
    sel_onehot = pend_q & (~pend_q + 5'd1);
    sel_idx    = '0;
    for (int i = 4; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = 3'(i);
    end
    wr_entry = '{btn: sel_idx, sw: sw_in, rpt: pend_rpt_q[sel_idx]};
  end

  // Hold timer: first period is REPEAT_DLY, later periods REPEAT_PER.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    hold_active = (btn_in != '0) && (btn_in == btn_prev_q);
    rpt_fire    = 1'b0;
    hold_cnt_d  = '0;
    rpt_phase_d = 1'b0;
    if (hold_active) begin
      if (hold_cnt_q == (rpt_phase_q ? PER_LAST : DLY_LAST)) begin
        rpt_fire    = 1'b1;
        rpt_phase_d = 1'b1;
      end else begin
        hold_cnt_d  = hold_cnt_q + CW'(1);
        rpt_phase_d = rpt_phase_q;
      end
    end
  end

  // A repeat on a bit still pending from a press leaves that press entry as-is.
  always_comb begin
    press      = btn_in & ~btn_prev_q;
    pend_left  = pend_q & ~sel_onehot;
    rpt_bits   = rpt_fire ? btn_in : 5'd0;
    pend_d     = pend_left | press | rpt_bits;
    pend_rpt_d = (pend_rpt_q & pend_left)
               | (rpt_bits & ~(pend_left & ~pend_rpt_q));
    pend_rpt_d = pend_rpt_d & ~press;
  end

  always_comb begin
    full     = (count_q == 5'(FIFO_DEPTH));
    pop      = evt_valid & evt_ready;
    push     = sel_valid & (~full | pop);
    drop     = sel_valid & full & ~pop;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    // NOTE: btn_prev tracks btn_in even in reset, so a button held through reset is not a press.
    btn_prev_q <= btn_in;
    if (rst) begin
      pend_q      <= '0;
      pend_rpt_q  <= '0;
      hold_cnt_q  <= '0;
      rpt_phase_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_rpt_q  <= pend_rpt_d;
      hold_cnt_q  <= hold_cnt_d;
      rpt_phase_q <= rpt_phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: queue storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head       = mem[rd_ptr_q];
    evt_valid  = (count_q != 5'd0);
    evt_btn    = evt_valid ? head.btn : 3'd0;
    evt_sw     = evt_valid ? head.sw  : 8'd0;
    evt_repeat = evt_valid ? head.rpt : 1'b0;
    fifo_count = count_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_btn_event_sched.sv
// Self-checking bench for btn_event_sched: directed scenarios followed by random
// stimulus, all compared every cycle against a queue-based behavioural model.
module tb_btn_event_sched;

  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  localparam int PER   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_in;
  logic [7:0] sw_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_btn;
  logic [7:0] evt_sw;
  logic       evt_repeat;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  always #5 clk = ~clk;

  btn_event_sched #(
    .FIFO_DEPTH(DEPTH),
    .REPEAT_DLY(DLY),
    .REPEAT_PER(PER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_btn   (evt_btn),
    .evt_sw    (evt_sw),
    .evt_repeat(evt_repeat),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  typedef struct packed {
    logic [2:0] btn;
    logic [7:0] sw;
    logic       rpt;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  ent_t       m_q[$];
  logic [4:0] m_pend = '0;
  logic [4:0] m_rptf = '0;
  logic [4:0] m_prev = '0;
  int         m_run  = 0;
  logic       m_ovf  = 1'b0;

  int exp_heads[4] = '{1, 2, 3, 2};
  bit exp_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  function automatic void model_edge();
    bit   pop, fire, drop;
    int   sz, idx;
    ent_t e;
    if (rst) begin
      m_prev = btn_in;
      m_pend = '0;
      m_rptf = '0;
      m_run  = 0;
      m_q.delete();
      m_ovf  = 1'b0;
      return;
    end
    sz  = m_q.size();
    pop = (sz != 0) && evt_ready;
    idx = -1;
    e   = '0;
    for (int i = 0; i < 5; i++) begin
      if (m_pend[i] && idx < 0) idx = i;
    end
    if (idx >= 0) begin
      e.btn = 3'(idx);
      e.sw  = sw_in;
      e.rpt = m_rptf[idx];
      m_pend[idx] = 1'b0;
    end
    if (btn_in != 5'd0 && btn_in == m_prev) m_run++;
    else m_run = 0;
    fire = (m_run >= DLY) && (((m_run - DLY) % PER) == 0);
    for (int i = 0; i < 5; i++) begin
      if (btn_in[i] && !m_prev[i]) begin
        m_pend[i] = 1'b1;
        m_rptf[i] = 1'b0;
      end else if (fire && btn_in[i]) begin
        if (!(m_pend[i] && !m_rptf[i])) m_rptf[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (pop) void'(m_q.pop_front());
    drop = (idx >= 0) && (sz >= DEPTH) && !pop;
    if (idx >= 0 && !drop) m_q.push_back(e);
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_prev = btn_in;
  endfunction

  task automatic compare_model();
    ent_t h;
    check("m_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check("m_count", 32'(fifo_count), 32'(m_q.size()));
    check("m_ovf", 32'(overflow), 32'(m_ovf));
    h = (m_q.size() != 0) ? m_q[0] : '0;
    check("m_btn", 32'(evt_btn), 32'(h.btn));
    check("m_sw", 32'(evt_sw), 32'(h.sw));
    check("m_rpt", 32'(evt_repeat), 32'(h.rpt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; btn_in = '0; sw_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_btn", 32'(evt_btn), 32'd0);
    rst = 1'b0;

    // Single press latency and one-cycle visibility with a ready consumer
    sw_in = 8'hA5; evt_ready = 1'b1; step();
    btn_in = 5'b00100; step();
    check("lat_k_valid", 32'(evt_valid), 32'd0);
    step();
    check("lat_valid", 32'(evt_valid), 32'd1);
    check("lat_btn", 32'(evt_btn), 32'd2);
    check("lat_sw", 32'(evt_sw), 32'hA5);
    check("lat_rpt", 32'(evt_repeat), 32'd0);
    btn_in = '0; step();
    check("lat_one_cycle", 32'(evt_valid), 32'd0);
    step();

    // Simultaneous presses drain in ascending order
    evt_ready = 1'b0; btn_in = 5'b10011; sw_in = 8'h3C;
    repeat (4) step();
    check("multi_count", 32'(fifo_count), 32'd3);
    btn_in = '0; step();
    evt_ready = 1'b1;
    check("multi_head0", 32'(evt_btn), 32'd0);
    step();
    check("multi_head1", 32'(evt_btn), 32'd1);
    step();
    check("multi_head4", 32'(evt_btn), 32'd4);
    step();
    check("multi_empty", 32'(fifo_count), 32'd0);

    // Overflow: five presses into a four-deep queue
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_in = 5'(1 << i); step();
      btn_in = '0; step();
    end
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(evt_btn), 32'd0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full queue: pop and push on the same edge
    btn_in = 5'b00100; step();
    check("fullpp_pre", 32'(fifo_count), 32'd4);
    evt_ready = 1'b1; step();
    check("fullpp_count", 32'(fifo_count), 32'd4);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b0; btn_in = '0; step();
    check("fullpp_hold", 32'(fifo_count), 32'd4);
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("fullpp_drain", 32'(evt_btn), 32'(exp_heads[j]));
      step();
    end
    check("fullpp_empty", 32'(fifo_count), 32'd0);

    // Auto-repeat: press event, then repeats 8 cycles after hold start, every 4
    step(); step();
    btn_in = 5'b00001;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) btn_in = '0;
      step();
      exp_v = (c == 1) || (c == 9) || (c == 13) || (c == 17);
      check("rep_valid", 32'(evt_valid), 32'(exp_v));
      if (exp_v) check("rep_flag", 32'(evt_repeat), 32'(c != 1));
    end

    // Mid-operation reset with a held button and queued events
    evt_ready = 1'b0;
    btn_in = 5'b00001; step();
    btn_in = '0; step();
    btn_in = 5'b01000; step(); step();
    check("rstq_count", 32'(fifo_count), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    check("rstq_valid", 32'(evt_valid), 32'd0);
    check("rstq_empty", 32'(fifo_count), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("rstq_quiet", 32'(evt_valid), 32'd0);
    end
    btn_in = '0; step(); step();
    btn_in = 5'b01000; step();
    check("rstq_edge_k", 32'(evt_valid), 32'd0);
    step();
    check("rstq_new_valid", 32'(evt_valid), 32'd1);
    check("rstq_new_btn", 32'(evt_btn), 32'd3);
    btn_in = '0; evt_ready = 1'b1; step(); step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 11) == 0) btn_in = 5'($urandom_range(0, 31));
      sw_in     = 8'($urandom);
      evt_ready = ((n / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
